// File: rtl/mem_access_stage_if.sv
// Bundle between the E/M register, the memory-access stage and the device bridge.
// The master side drives instruction fields and bridge read data; the slave side is the stage.
interface mem_access_stage_if;
  logic [31:0] i_pc;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        i_we;
  logic [1:0]  i_s;
  logic [2:0]  i_l;
  logic        i_ld;
  logic [4:0]  i_ex;
  logic        i_flush;
  logic [31:0] pr_rdata;
  logic [31:0] o_rdata;
  logic [4:0]  o_ex;
  logic [31:0] pr_addr;
  logic [31:0] pr_wdata;
  logic        pr_we;

  modport master (
    output i_pc, i_addr, i_wdata, i_we, i_s, i_l, i_ld, i_ex, i_flush, pr_rdata,
    input  o_rdata, o_ex, pr_addr, pr_wdata, pr_we
  );

  modport slave (
    input  i_pc, i_addr, i_wdata, i_we, i_s, i_l, i_ld, i_ex, i_flush, pr_rdata,
    output o_rdata, o_ex, pr_addr, pr_wdata, pr_we
  );
endinterface

// File: rtl/mem_access_stage.sv
// MIPS memory-access stage: owns the data memory, applies byte-enabled stores, extends loads,
// routes device-window accesses to the bridge and raises AdEL/AdES address exceptions.
module mem_access_stage #(
  parameter int unsigned DM_WORDS = 3072,
  parameter logic [31:0] DEV_BASE = 32'h0000_7F00,
  parameter logic [31:0] DEV_TOP  = 32'h0000_7F1B
) (
  input logic               clk,
  input logic               reset,
  mem_access_stage_if.slave bus
);

  localparam int unsigned AW       = $clog2(DM_WORDS);
  localparam logic [31:0] DmBytes  = 32'(DM_WORDS * 4);
  localparam logic [4:0]  ExcAdEL  = 5'd4;
  localparam logic [4:0]  ExcAdES  = 5'd5;
  localparam logic [31:0] RoCount0 = DEV_BASE + 32'h8;
  localparam logic [31:0] RoCount1 = DEV_BASE + 32'h18;

  typedef enum logic [1:0] {WidWord, WidHalf, WidByte} width_e;

  logic [31:0] mem [DM_WORDS];

  logic [AW-1:0] idx;
  logic [1:0]    boff;
  logic          dm_hit;
  logic          dev_hit;
  logic          ro_hit;
  width_e        st_width;
  width_e        ld_width;
  logic          ld_signed;
  logic          ld_bad;
  logic          st_bad;
  logic [4:0]    ex;
  logic          commit;
  logic          dm_we;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   dm_word;
  logic [31:0]   src_word;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   rdata;

  // The PC travels with the instruction for the M/W register; this stage does not consume it.
  logic unused_pc;
  assign unused_pc = ^bus.i_pc;

  assign idx  = bus.i_addr[AW+1:2];
  assign boff = bus.i_addr[1:0];

  // Region decode uses the full address so nothing above the DM range aliases into it.
  assign dm_hit  = bus.i_addr < DmBytes;
  assign dev_hit = (bus.i_addr >= DEV_BASE) && (bus.i_addr <= DEV_TOP);
  assign ro_hit  = (bus.i_addr == RoCount0) || (bus.i_addr == RoCount1);

  always_comb begin
    st_width = WidWord;
    case (bus.i_s)
      2'd1:    st_width = WidHalf;
      2'd2:    st_width = WidByte;
      default: st_width = WidWord;
    endcase
  end

  always_comb begin
    ld_width  = WidWord;
    ld_signed = 1'b0;
    case (bus.i_l)
      3'd1:    ld_width = WidByte;
      3'd2: begin
        ld_width  = WidByte;
        ld_signed = 1'b1;
      end
      3'd3:    ld_width = WidHalf;
      3'd4: begin
        ld_width  = WidHalf;
        ld_signed = 1'b1;
      end
      default: ld_width = WidWord;
    endcase
  end

  function automatic logic access_bad(width_e w, logic [1:0] off, logic dm, logic dev);
    logic mis;
    mis = 1'b0;
    case (w)
      WidWord: mis = (off != 2'b00);
      WidHalf: mis = off[0];
      default: mis = 1'b0;
    endcase
    return mis || !(dm || dev) || (dev && (w != WidWord));
  endfunction

  assign ld_bad = access_bad(ld_width, boff, dm_hit, dev_hit);
  assign st_bad = access_bad(st_width, boff, dm_hit, dev_hit) || ro_hit;

  always_comb begin
    ex = 5'd0;
    if (bus.i_ex != 5'd0) begin
      ex = bus.i_ex;
    end else if (bus.i_ld && ld_bad) begin
      ex = ExcAdEL;
    end else if (bus.i_we && st_bad) begin
      ex = ExcAdES;
    end
  end

  assign commit = bus.i_we && (ex == 5'd0) && !bus.i_flush && !reset;
  assign dm_we  = commit && dm_hit;

  always_comb begin
    be    = 4'b1111;
    wlane = bus.i_wdata;
    case (st_width)
      WidHalf: begin
        be    = 4'b0011 << {boff[1], 1'b0};
        wlane = {2{bus.i_wdata[15:0]}};
      end
      WidByte: begin
        be    = 4'b0001 << boff;
        wlane = {4{bus.i_wdata[7:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = bus.i_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DM_WORDS); i++) begin
        mem[i] <= '0;
      end
    end else if (dm_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= wlane[8*b +: 8];
        end
      end
    end
  end

  assign dm_word  = dm_hit ? mem[idx] : '0;
  assign src_word = dev_hit ? bus.pr_rdata : dm_word;

  always_comb begin
    ld_byte = src_word[7:0];
    case (boff)
      2'd1:    ld_byte = src_word[15:8];
      2'd2:    ld_byte = src_word[23:16];
      2'd3:    ld_byte = src_word[31:24];
      default: ld_byte = src_word[7:0];
    endcase
    ld_half = boff[1] ? src_word[31:16] : src_word[15:0];
  end

  always_comb begin
    rdata = src_word;
    case (ld_width)
      WidByte: rdata = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      WidHalf: rdata = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: rdata = src_word;
    endcase
  end

  assign bus.o_rdata  = rdata;
  assign bus.o_ex     = ex;
  assign bus.pr_addr  = bus.i_addr;
  assign bus.pr_wdata = bus.i_wdata;
  assign bus.pr_we    = commit && dev_hit;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a table of one-cycle vectors plus reset/latency sequences.
module tb_mem_access_stage;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mem_access_stage_if bus ();

  mem_access_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [1:0] SW = 2'd0, SH = 2'd1, SB = 2'd2, SRSV = 2'd3;
  localparam logic [2:0] LW = 3'd0, LBU = 3'd1, LB = 3'd2, LHU = 3'd3, LH = 3'd4, LRSV = 3'd6;

  typedef struct {
    logic        we;
    logic [1:0]  s;
    logic        ld;
    logic [2:0]  l;
    logic [4:0]  ex;
    logic        flush;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prd;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [4:0]  exp_ex;
    logic        exp_prwe;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_st(input logic [1:0] s, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] exp_ex, input logic exp_prwe,
                        input logic flush = 1'b0, input logic [4:0] ex = 5'd0);
    vec_t v;
    v = '{we: 1'b1, s: s, ld: 1'b0, l: LW, ex: ex, flush: flush, addr: addr, wdata: wdata,
          prd: 32'h0, chk_rd: 1'b0, exp_rd: 32'h0, exp_ex: exp_ex, exp_prwe: exp_prwe};
    vecs.push_back(v);
  endtask

  task automatic add_ld(input logic [2:0] l, input logic [31:0] addr, input logic [31:0] prd,
                        input logic chk, input logic [31:0] exp_rd, input logic [4:0] exp_ex,
                        input logic [4:0] ex = 5'd0);
    vec_t v;
    v = '{we: 1'b0, s: SW, ld: 1'b1, l: l, ex: ex, flush: 1'b0, addr: addr, wdata: 32'h0,
          prd: prd, chk_rd: chk, exp_rd: exp_rd, exp_ex: exp_ex, exp_prwe: 1'b0};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic we, input logic [1:0] s, input logic ld, input logic [2:0] l,
                       input logic [4:0] ex, input logic flush, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] prd);
    bus.i_pc     = 32'h0040_0000 + addr;
    bus.i_we     = we;
    bus.i_s      = s;
    bus.i_ld     = ld;
    bus.i_l      = l;
    bus.i_ex     = ex;
    bus.i_flush  = flush;
    bus.i_addr   = addr;
    bus.i_wdata  = wdata;
    bus.pr_rdata = prd;
  endtask

  task automatic idle();
    drive(1'b0, SW, 1'b0, LW, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  // One-cycle store or load helpers for the hand-written sequences (drive at negedge).
  task automatic do_sw(input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    drive(1'b1, SW, 1'b0, LW, 5'd0, 1'b0, addr, wdata, 32'h0);
  endtask

  task automatic chk_lw(input string name, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    drive(1'b0, SW, 1'b1, LW, 5'd0, 1'b0, addr, 32'h0, 32'h0);
    #1;
    check({name, " o_ex"}, 32'(bus.o_ex), 32'h0);
    check({name, " o_rdata"}, bus.o_rdata, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst o_rdata", bus.o_rdata, 32'h0);
    check("rst o_ex", 32'(bus.o_ex), 32'h0);
    check("rst pr_we", 32'(bus.pr_we), 32'h0);
    check("rst pr_addr", bus.pr_addr, 32'h0);
    check("rst pr_wdata", bus.pr_wdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Store merge
    add_st(SW, 32'h10, 32'h1234_5678, 5'd0, 1'b0);
    add_st(SB, 32'h11, 32'h0000_00AB, 5'd0, 1'b0);
    add_st(SH, 32'h12, 32'h0000_CDEF, 5'd0, 1'b0);
    add_ld(LW, 32'h10, 32'h0, 1'b1, 32'hCDEF_AB78, 5'd0);
    // Load extension
    add_st(SW, 32'h20, 32'h0000_8080, 5'd0, 1'b0);
    add_ld(LB,  32'h20, 32'h0, 1'b1, 32'hFFFF_FF80, 5'd0);
    add_ld(LBU, 32'h20, 32'h0, 1'b1, 32'h0000_0080, 5'd0);
    add_ld(LH,  32'h20, 32'h0, 1'b1, 32'hFFFF_8080, 5'd0);
    add_ld(LHU, 32'h20, 32'h0, 1'b1, 32'h0000_8080, 5'd0);
    add_ld(LB,  32'h21, 32'h0, 1'b1, 32'hFFFF_FF80, 5'd0);
    add_ld(LBU, 32'h23, 32'h0, 1'b1, 32'h0000_0000, 5'd0);
    add_ld(LH,  32'h22, 32'h0, 1'b1, 32'h0000_0000, 5'd0);
    // Address faults
    add_ld(LW, 32'h22, 32'h0, 1'b0, 32'h0, 5'd4);
    add_st(SH, 32'h21, 32'h0000_BEEF, 5'd5, 1'b0);
    add_ld(LW, 32'h20, 32'h0, 1'b1, 32'h0000_8080, 5'd0);
    add_ld(LW, 32'h3000, 32'h0, 1'b0, 32'h0, 5'd4);
    add_ld(LW, 32'h2FFC, 32'h0, 1'b1, 32'h0, 5'd0);
    add_ld(LW, 32'h0001_0010, 32'h0, 1'b0, 32'h0, 5'd4);
    add_st(SB, 32'h7F04, 32'h0000_0011, 5'd5, 1'b0);
    add_st(SW, 32'h7F08, 32'h0000_0022, 5'd5, 1'b0);
    add_st(SW, 32'h7F18, 32'h0000_0033, 5'd5, 1'b0);
    add_ld(LH, 32'h7F04, 32'h0, 1'b0, 32'h0, 5'd4);
    add_ld(LW, 32'h7F1C, 32'h0, 1'b0, 32'h0, 5'd4);
    add_ld(LW, 32'h10, 32'h0, 1'b0, 32'h0, 5'd12, 5'd12);
    add_ld(LW, 32'h22, 32'h0, 1'b0, 32'h0, 5'd12, 5'd12);
    add_st(SW, 32'h7F04, 32'h0000_0055, 5'd3, 1'b0, 1'b0, 5'd3);
    // Squash
    add_st(SW, 32'h40, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b1);
    add_ld(LW, 32'h40, 32'h0, 1'b1, 32'h0, 5'd0);
    add_st(SW, 32'h7F04, 32'h0000_0055, 5'd0, 1'b0, 1'b1);
    // Device path and reserved encodings
    add_st(SW, 32'h7F04, 32'h0000_0055, 5'd0, 1'b1);
    add_ld(LW, 32'h7F08, 32'h0000_0099, 1'b1, 32'h0000_0099, 5'd0);
    add_ld(LW, 32'h7F00, 32'h8765_4321, 1'b1, 32'h8765_4321, 5'd0);
    add_st(SRSV, 32'h30, 32'hDEAD_BEEF, 5'd0, 1'b0);
    add_ld(LRSV, 32'h30, 32'h0, 1'b1, 32'hDEAD_BEEF, 5'd0);
    add_ld(LW, 32'h0000_4030, 32'h0, 1'b0, 32'h0, 5'd4);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].s, vecs[i].ld, vecs[i].l, vecs[i].ex, vecs[i].flush,
            vecs[i].addr, vecs[i].wdata, vecs[i].prd);
      #1;
      check($sformatf("v%0d o_ex", i), 32'(bus.o_ex), 32'(vecs[i].exp_ex));
      check($sformatf("v%0d pr_we", i), 32'(bus.pr_we), 32'(vecs[i].exp_prwe));
      check($sformatf("v%0d pr_addr", i), bus.pr_addr, vecs[i].addr);
      check($sformatf("v%0d pr_wdata", i), bus.pr_wdata, vecs[i].wdata);
      if (vecs[i].chk_rd) begin
        check($sformatf("v%0d o_rdata", i), bus.o_rdata, vecs[i].exp_rd);
      end
    end

    // No access at an unmapped address raises nothing.
    @(negedge clk);
    drive(1'b0, SW, 1'b0, LW, 5'd0, 1'b0, 32'h5001, 32'h0, 32'h0);
    #1;
    check("noacc o_ex", 32'(bus.o_ex), 32'h0);

    // Same-cycle read sees old contents; next cycle sees the new word.
    do_sw(32'h50, 32'hA5A5_5A5A);
    #1;
    check("lat same-cycle", bus.o_rdata, 32'h0);
    chk_lw("lat next-cycle", 32'h50, 32'hA5A5_5A5A);

    // Reset mid-stream drops the in-flight store and clears memory.
    for (int a = 0; a < 16; a++) begin
      do_sw(32'(a * 4), 32'h1111_1111 * 32'(a + 1));
    end
    chk_lw("fill 0x3c", 32'h3C, 32'h1111_1111 * 32'd16);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, SW, 1'b0, LW, 5'd0, 1'b0, 32'h7F04, 32'h1, 32'h0);
    #1;
    check("rst dev pr_we", 32'(bus.pr_we), 32'h0);
    @(negedge clk);
    drive(1'b1, SW, 1'b0, LW, 5'd0, 1'b0, 32'h0, 32'h1, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    idle();
    for (int a = 0; a < 16; a++) begin
      chk_lw($sformatf("post-rst @%0h", a * 4), 32'(a * 4), 32'h0);
    end
    chk_lw("post-rst @50", 32'h50, 32'h0);
    do_sw(32'h4, 32'h77);
    chk_lw("resume @4", 32'h4, 32'h77);

    @(negedge clk);
    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the five-stage MIPS pipeline. It sits directly downstream of the E/M pipeline register and consumes its address, store data, access-type and exception fields. It owns the 12 KiB data memory, performs byte/half/word stores with byte enables and sign/zero-extended loads, and routes device-range accesses to the bridge. It detects address exceptions; its results feed the M/W register.

## Interface
Parameters:
- DM_WORDS, 3072, data-memory depth in 32-bit words (byte range 0x0000_0000–0x0000_2FFF)
- DEV_BASE, 32'h0000_7F00, first byte of device window
- DEV_TOP, 32'h0000_7F1B, last byte of device window

Ports:
- clk  in  1  clock; memory writes on rising edge
- reset  in  1  reset, synchronous, active-high
- i_pc  in  32  PC of instruction in M
- i_addr  in  32  effective address (ALU result)
- i_wdata  in  32  store data (forwarded rt)
- i_we  in  1  instruction is a store
- i_s  in  2  store width: 0 sw, 1 sh, 2 sb, 3 reserved (treated as sw)
- i_l  in  3  load type: 0 lw, 1 lbu, 2 lb, 3 lhu, 4 lh, 5–7 treated as lw
- i_ld  in  1  instruction is a load
- i_ex  in  5  exception code from earlier stages (0 = none)
- i_flush  in  1  exception/interrupt commit this cycle; squash store
- pr_rdata  in  32  bridge read data
- o_rdata  out  32  extended load result
- o_ex  out  5  exception code to M/W
- pr_addr  out  32  bridge address (= i_addr)
- pr_wdata  out  32  bridge write data (= i_wdata)
- pr_we  out  1  bridge write strobe

## Operation
- Storage: DM_WORDS × 32 array, indexed by i_addr[13:2]. Reads are asynchronous; writes occur on the rising clk edge.
- Region decode:
  - DM hit: i_addr < 4·DM_WORDS.
  - DEV hit: DEV_BASE ≤ i_addr ≤ DEV_TOP.
  - Anything else is a miss.
- Exception priority:
  1. i_ex ≠ 0: o_ex = i_ex.
  2. Load fault: o_ex = 4 (AdEL) when i_ld and any of:
     - word access with addr[1:0] ≠ 0;
     - half access with addr[0] ≠ 0;
     - miss;
     - DEV hit with half/byte width.
  3. Store fault: o_ex = 5 (AdES) under the same conditions with i_we, or a store to DEV_BASE+8 or DEV_BASE+0x18 (read-only count registers).
  4. Otherwise o_ex = 0.
- Commit: a store commits only when i_we=1, o_ex=0, i_flush=0 and reset=0.
- DM write byte enables:
  - sw: 4'b1111.
  - sh: 4'b0011 << (2·addr[1]), data = {2{wdata[15:0]}}.
  - sb: 4'b0001 << addr[1:0], data = {4{wdata[7:0]}}.
  - Unenabled bytes are retained.
- Device write: pr_we = commit & DEV hit.
- Load path:
  - Source word is DEV hit ? pr_rdata : DM word.
  - Byte lane is selected by addr[1:0]; half lane by addr[1].
  - lb and lh sign-extend; lbu and lhu zero-extend.
  - If o_ex ≠ 0, o_rdata is don't-care; the bench must not check it.
- Reset: on a rising edge with reset=1, every DM word clears to 0, and no write occurs that cycle regardless of i_we.

## Timing
- o_rdata, o_ex, pr_we and pr_addr are combinational from inputs and current array contents; zero added latency, so M/W captures them on the same edge.
- Store latency: data is visible to a read of the same address in the cycle after the commit edge. A same-cycle read returns the old contents.
- Reset values with all inputs 0: o_rdata=0, o_ex=0, pr_we=0, pr_addr=0, pr_wdata=0. All DM words read 0 after the reset edge.
- Reset asserted mid-stream, including a store in M: the store is dropped and memory clears. Operation resumes on the first edge with reset=0.
- i_flush and a store in the same cycle: the store is dropped; o_ex is unaffected.
- Address wrap: i_addr ≥ 4·DM_WORDS never aliases into DM. It always faults unless it is a DEV hit.

## Test plan
- Store merge: sw 0x12345678 @0x10; sb 0xAB @0x11; sh 0xCDEF @0x12; then lw @0x10 -> 0xCDEFAB78.
- Load extension with word 0x0000_8080 @0x20: lb @0x20 -> 0xFFFF_FF80; lbu -> 0x0000_0080; lh -> 0xFFFF_8080; lhu -> 0x0000_8080.
- Address faults:
  - lw @0x22 -> o_ex=4;
  - sh @0x21 -> o_ex=5 with memory unchanged;
  - lw @0x3000 -> 4;
  - sb @0x7F04 -> 5;
  - sw @0x7F08 -> 5 with pr_we=0;
  - i_ex=12 with a valid lw -> o_ex=12.
- Squash: sw 0xFFFF_FFFF @0x40 with i_flush=1 -> pr_we=0; the next-cycle lw @0x40 -> its prior value.
- Device path: sw 0x55 @0x7F04 -> pr_we=1 and pr_addr=0x7F04 for one cycle; lw @0x7F08 with pr_rdata=0x99 -> o_rdata=0x99.
- Reset: fill 0x0–0x3C; assert reset one cycle concurrent with sw 0x1 @0x0 -> all lw reads return 0 afterwards.
